// File: rtl/pulse_param_pkg.sv
// Shared constants and types for the pulse parameter loader: framing bytes,
// command codes, shadow-index map and parser state/op encodings.
package pulse_param_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [3:0] CMD_WRITE_HI = 4'h1;
  localparam logic [7:0] CMD_COMMIT   = 8'h20;
  localparam logic [7:0] CMD_CLEAR    = 8'h30;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int unsigned NUM_REGS = 16;

  localparam int unsigned IDX_POS1DUR      = 0;
  localparam int unsigned IDX_POS1PAUSEDUR = 1;
  localparam int unsigned IDX_POS2DUR      = 2;
  localparam int unsigned IDX_POS2PAUSEDUR = 3;
  localparam int unsigned IDX_POS3DUR      = 4;
  localparam int unsigned IDX_POS3PAUSEDUR = 5;
  localparam int unsigned IDX_POS4DUR      = 6;
  localparam int unsigned IDX_POS4PAUSEDUR = 7;
  localparam int unsigned IDX_NEG1DUR      = 8;
  localparam int unsigned IDX_NEG1PAUSEDUR = 9;
  localparam int unsigned IDX_NEG2DUR      = 10;
  localparam int unsigned IDX_NEG2PAUSEDUR = 11;
  localparam int unsigned IDX_NEG3DUR      = 12;
  localparam int unsigned IDX_NEG3PAUSEDUR = 13;
  localparam int unsigned IDX_NEG4DUR      = 14;
  localparam int unsigned IDX_NEG4PAUSEDUR = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_CSUM,
    ST_EXEC
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WRITE,
    OP_COMMIT,
    OP_CLEAR
  } op_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pulse_frame_parser.sv
// Host byte-stream frame parser: sync/cmd/data/checksum FSM with a mid-frame
// idle timeout; presents one decoded operation during the EXEC cycle.
module pulse_frame_parser
  import pulse_param_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        exec_valid,
  output op_t         exec_op,
  output logic [3:0]  exec_index,
  output logic [31:0] exec_data,
  output logic [7:0]  err_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  op_t              op;
  logic [3:0]       index;
  logic [31:0]      data;
  logic [7:0]       csum;
  logic [1:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             accept;

  assign accept     = rx_valid && rx_ready;
  assign exec_op    = op;
  assign exec_index = index;
  assign exec_data  = data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      op         <= OP_NONE;
      index      <= '0;
      data       <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      err_count  <= '0;
      rx_ready   <= 1'b1;
      exec_valid <= 1'b0;
    end else begin
      rx_ready   <= 1'b1;
      exec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (accept && rx_data == SYNC_BYTE) state <= ST_CMD;
        end
        ST_EXEC: state <= ST_IDLE;
        default: begin
          // An accepted byte always wins over a timeout firing in the same cycle.
          if (accept) begin
            tmo_cnt <= '0;
            if (state == ST_CMD) begin
              csum     <= rx_data;
              byte_cnt <= '0;
              if (rx_data[7:4] == CMD_WRITE_HI) begin
                op    <= OP_WRITE;
                index <= rx_data[3:0];
                state <= ST_DATA;
              end else if (rx_data == CMD_COMMIT) begin
                op    <= OP_COMMIT;
                state <= ST_CSUM;
              end else if (rx_data == CMD_CLEAR) begin
                op    <= OP_CLEAR;
                state <= ST_CSUM;
              end else begin
                state     <= ST_IDLE;
                err_count <= sat_inc8(err_count);
              end
            end else if (state == ST_DATA) begin
              data     <= {data[23:0], rx_data};
              csum     <= csum ^ rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) state <= ST_CSUM;
            end else begin
              if (rx_data == csum) begin
                state      <= ST_EXEC;
                rx_ready   <= 1'b0;
                exec_valid <= 1'b1;
              end else begin
                state     <= ST_IDLE;
                err_count <= sat_inc8(err_count);
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt   <= '0;
            state     <= ST_IDLE;
            err_count <= sat_inc8(err_count);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Pulse parameter loader: shadow bank written by host frames, copied
// atomically to the active duration outputs on COMMIT.
module pulse_param_loader
  import pulse_param_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned DUR_W          = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [DUR_W-1:0] pos1dur,
  output logic [DUR_W-1:0] pos1pausedur,
  output logic [DUR_W-1:0] pos2dur,
  output logic [DUR_W-1:0] pos2pausedur,
  output logic [DUR_W-1:0] pos3dur,
  output logic [DUR_W-1:0] pos3pausedur,
  output logic [DUR_W-1:0] pos4dur,
  output logic [DUR_W-1:0] pos4pausedur,
  output logic [DUR_W-1:0] neg1dur,
  output logic [DUR_W-1:0] neg1pausedur,
  output logic [DUR_W-1:0] neg2dur,
  output logic [DUR_W-1:0] neg2pausedur,
  output logic [DUR_W-1:0] neg3dur,
  output logic [DUR_W-1:0] neg3pausedur,
  output logic [DUR_W-1:0] neg4dur,
  output logic [DUR_W-1:0] neg4pausedur,
  output logic             cfg_valid,
  output logic             commit_pulse,
  output logic [7:0]       err_count
);

  logic             exec_valid;
  op_t              exec_op;
  logic [3:0]       exec_index;
  logic [31:0]      exec_data;
  logic [DUR_W-1:0] wr_val;
  logic [DUR_W-1:0] shadow [NUM_REGS];
  logic [DUR_W-1:0] active [NUM_REGS];

  pulse_frame_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .exec_valid(exec_valid),
    .exec_op   (exec_op),
    .exec_index(exec_index),
    .exec_data (exec_data),
    .err_count (err_count)
  );

  assign wr_val = DUR_W'(exec_data);

  // Reset has priority, so a reset landing on the EXEC cycle drops the update.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      cfg_valid    <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      if (exec_valid) begin
        case (exec_op)
          OP_WRITE: shadow[exec_index] <= wr_val;
          OP_COMMIT: begin
            for (int unsigned i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
            cfg_valid    <= 1'b1;
            commit_pulse <= 1'b1;
          end
          OP_CLEAR: begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pos1dur      = active[IDX_POS1DUR];
  assign pos1pausedur = active[IDX_POS1PAUSEDUR];
  assign pos2dur      = active[IDX_POS2DUR];
  assign pos2pausedur = active[IDX_POS2PAUSEDUR];
  assign pos3dur      = active[IDX_POS3DUR];
  assign pos3pausedur = active[IDX_POS3PAUSEDUR];
  assign pos4dur      = active[IDX_POS4DUR];
  assign pos4pausedur = active[IDX_POS4PAUSEDUR];
  assign neg1dur      = active[IDX_NEG1DUR];
  assign neg1pausedur = active[IDX_NEG1PAUSEDUR];
  assign neg2dur      = active[IDX_NEG2DUR];
  assign neg2pausedur = active[IDX_NEG2PAUSEDUR];
  assign neg3dur      = active[IDX_NEG3DUR];
  assign neg3pausedur = active[IDX_NEG3PAUSEDUR];
  assign neg4dur      = active[IDX_NEG4DUR];
  assign neg4pausedur = active[IDX_NEG4PAUSEDUR];

endmodule
